sonar_tx_frame: RTL and testbench
=================================

Name: sonar_tx_frame

Overview:
Downstream transmit stage of the sonar. Consumes one angle and one distance reading (3 BCD digits each) and sends them as a fixed ASCII frame on the serial line, e.g. "090,123#". Frame formatting, character sequencing and the UART bit engine are all in this block. The system control unit drives partida and waits for pronto before the next servo step.

Parameters:
CLKS_PER_BIT, 434, clock cycles per serial bit (50 MHz / 115200 baud); must be >= 2.
N_CHARS, 8, characters per frame without the optional suffix; fixed value, not for override.

Ports:
clock  input  1  system clock.
reset  input  1  synchronous, active-high reset.
partida  input  1  start pulse; sampled only in IDLE.
angulo  input  12  angle in BCD: [11:8] hundreds, [7:4] tens, [3:0] units.
distancia  input  12  distance in BCD, same digit layout.
saida_serial  output  1  UART TX line; idles high.
ocupado  output  1  high while a frame is in progress.
pronto  output  1  one-cycle pulse at end of frame.
db_estado  output  4  encoded FSM state, for the 7-segment debug display.

Behaviour:
- Reset values: saida_serial=1, ocupado=0, pronto=0, db_estado=0 (IDLE). Character index=0, bit counter=0, tick counter=0.
- Reset asserted mid-frame: next cycle saida_serial=1, FSM in IDLE, no pronto pulse. The partial frame is abandoned.
- Serial format, 7O2: start bit 0; 7 data bits LSB first; odd parity bit (ones in data+parity are odd); two stop bits of 1. 11 bits per character, each held CLKS_PER_BIT cycles.
- Frame order: A2 A1 A0 ',' D2 D1 D0 '#'.
  - Digit d in 0..9 maps to 0x30+d.
  - Digit >9 maps to '?' (0x3F).
  - ',' = 0x2C; '#' = 0x23.
- Input capture: angulo and distancia are latched in the cycle partida is accepted. Later input changes do not affect the frame in flight.
- FSM states:
  - IDLE (0): line high. partida=1 -> latch inputs, index=0 -> LOAD.
  - LOAD (1): select character[index], compute parity -> SEND.
  - SEND (2): bit engine shifts out 11 bits -> NEXT when the last stop-bit period ends.
  - NEXT (3): if index=last -> DONE; else index++ -> LOAD.
  - DONE (4): pronto=1 for one cycle -> IDLE.
- Latency:
  - partida accepted at cycle 0; start bit of char 0 appears on saida_serial at cycle 2 (LOAD, then SEND with registered output).
  - LOAD and NEXT each add one cycle between characters, during which the line stays high.
  - Total: pronto high at cycle 2 + 8*(11*CLKS_PER_BIT + 2) - 1.
- ocupado: 1 in LOAD, SEND, NEXT and DONE; 0 in IDLE.
- partida while ocupado=1: ignored, no queuing.
- partida in the cycle after DONE (FSM back in IDLE): accepted normally.
- Counter widths: tick counter is $clog2(CLKS_PER_BIT) bits; bit counter 4 bits; index 4 bits.

Optional Feature:
SONAR_TX_CRLF_EN:
- Defined: frame extended to 10 characters by appending CR (0x0D) and LF (0x0A) after '#'. Latency formula uses 10 in place of 8.
- Undefined: frame is exactly 8 characters, with no CR/LF logic.

Decomposition:
- Package sonar_pkg holds:
  - ASCII constants: ZERO=0x30, COMMA=0x2C, HASH=0x23, QMARK=0x3F, CR, LF.
  - FSM state enum with the db_estado encodings above.
  - Function bcd_to_ascii(4-bit) -> 7-bit.
- Sub-module uart_tx_7o2 owns the bit engine:
  - Inputs: clock, reset, start, 7-bit data.
  - Outputs: saida_serial, fim (one-cycle pulse at end of the second stop bit).
  - Parity is generated inside it.
  - Parameter: CLKS_PER_BIT.

Test Plan:
- CLKS_PER_BIT=4; angulo=0x090, distancia=0x123; pulse partida.
  -> Decoded chars 0x30,0x39,0x30,0x2C,0x31,0x32,0x33,0x23.
  -> Each character: start 0, odd parity correct, two stop bits.
  -> pronto at cycle 2+8*46-1=369.
- Digit out of range: angulo=0x0A5 -> second character is 0x3F ('?').
- Busy handling: second partida pulse mid-frame -> ignored; exactly one pronto. Changing angulo mid-frame does not alter the transmitted characters.
- Back-to-back: partida in the cycle after the pronto pulse -> second frame starts; start bit at +2 cycles.
- Reset mid-frame: reset during char 3 -> saida_serial=1 and ocupado=0 the next cycle; no pronto; a following partida produces a full correct frame.
- SONAR_TX_CRLF_EN defined: same stimulus as the first test -> 10 characters ending 0x0D,0x0A; pronto at cycle 2+10*46-1=461.

Source files
------------

// File: rtl/sonar_tx_frame_pkg.sv
// Shared constants, FSM state encoding and BCD-to-ASCII helper for the sonar transmit stage.
// Optional CR/LF frame suffix is enabled with `define SONAR_TX_CRLF_EN.
package sonar_pkg;

  localparam int N_CHARS = 8;
`ifdef SONAR_TX_CRLF_EN
  localparam int N_FRAME = N_CHARS + 2;
`else
  localparam int N_FRAME = N_CHARS;
`endif

  localparam logic [6:0] ZERO  = 7'h30;
  localparam logic [6:0] COMMA = 7'h2C;
  localparam logic [6:0] HASH  = 7'h23;
  localparam logic [6:0] QMARK = 7'h3F;
  localparam logic [6:0] CR    = 7'h0D;
  localparam logic [6:0] LF    = 7'h0A;

  // Encodings are shown directly on the debug display.
  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_LOAD = 4'd1,
    ST_SEND = 4'd2,
    ST_NEXT = 4'd3,
    ST_DONE = 4'd4
  } state_t;

  function automatic logic [6:0] bcd_to_ascii(input logic [3:0] digit);
    if (digit > 4'd9) return QMARK;
    return ZERO + {3'b000, digit};
  endfunction

endpackage

// File: rtl/sonar_tx_frame_if.sv
// Control and serial-line bundle between the system control unit and the sonar transmit stage.
interface sonar_tx_frame_if;
  // partida is a start pulse honoured only while ocupado is low; the block answers with a
  // single-cycle pronto after the last character, and ignores partida until then (no queuing).
  logic        partida;
  logic [11:0] angulo;
  logic [11:0] distancia;
  logic        saida_serial;
  logic        ocupado;
  logic        pronto;
  logic [3:0]  db_estado;

  modport master (
    output partida, angulo, distancia,
    input  saida_serial, ocupado, pronto, db_estado
  );

  modport slave (
    input  partida, angulo, distancia,
    output saida_serial, ocupado, pronto, db_estado
  );
endinterface

// File: rtl/sonar_tx_frame_uart_tx_7o2.sv
// UART transmit engine, 7 data bits, odd parity, 2 stop bits; each bit held CLKS_PER_BIT clocks.
module uart_tx_7o2 #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [6:0] data,
  output logic       saida_serial,
  output logic       fim
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] TICK_MAX = TW'(CLKS_PER_BIT - 1);

  logic          busy;
  logic [TW-1:0] tick;
  logic [3:0]    bit_cnt;
  logic [9:0]    shreg;

  // bit_cnt names the bit currently on the line: 0 = start, 10 = second stop bit.
  assign fim = busy && (tick == TICK_MAX) && (bit_cnt == 4'd10);

  always_ff @(posedge clock) begin
    if (reset) begin
      saida_serial <= 1'b1;
      busy         <= 1'b0;
      tick         <= '0;
      bit_cnt      <= '0;
      shreg        <= '1;
    end else if (!busy) begin
      if (start) begin
        saida_serial <= 1'b0;
        shreg        <= {2'b11, ~^data, data};
        tick         <= '0;
        bit_cnt      <= '0;
        busy         <= 1'b1;
      end
    end else if (tick == TICK_MAX) begin
      tick <= '0;
      if (bit_cnt == 4'd10) begin
        busy         <= 1'b0;
        saida_serial <= 1'b1;
      end else begin
        bit_cnt      <= bit_cnt + 4'd1;
        saida_serial <= shreg[0];
        shreg        <= {1'b1, shreg[9:1]};
      end
    end else begin
      tick <= tick + 1'b1;
    end
  end

endmodule

// File: rtl/sonar_tx_frame.sv
// Sonar transmit stage: formats angle/distance BCD readings into an ASCII frame "AAA,DDD#"
// and sends it over a 7O2 UART. `define SONAR_TX_CRLF_EN appends CR LF to each frame.
module sonar_tx_frame
  import sonar_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic              clock,
  input  logic              reset,
  sonar_tx_frame_if.slave   bus
);

  localparam logic [3:0] LAST_IDX = 4'(N_FRAME - 1);

  state_t      state;
  logic [3:0]  idx;
  logic [11:0] ang_q;
  logic [11:0] dist_q;
  logic        pronto_q;
  logic [6:0]  char_sel;
  logic        fim;

  always_comb begin
    char_sel = HASH;
    case (idx)
      4'd0: char_sel = bcd_to_ascii(ang_q[11:8]);
      4'd1: char_sel = bcd_to_ascii(ang_q[7:4]);
      4'd2: char_sel = bcd_to_ascii(ang_q[3:0]);
      4'd3: char_sel = COMMA;
      4'd4: char_sel = bcd_to_ascii(dist_q[11:8]);
      4'd5: char_sel = bcd_to_ascii(dist_q[7:4]);
      4'd6: char_sel = bcd_to_ascii(dist_q[3:0]);
      4'd7: char_sel = HASH;
`ifdef SONAR_TX_CRLF_EN
      4'd8: char_sel = CR;
      4'd9: char_sel = LF;
`endif
      default: char_sel = HASH;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= ST_IDLE;
      idx      <= '0;
      ang_q    <= '0;
      dist_q   <= '0;
      pronto_q <= 1'b0;
    end else begin
      pronto_q <= 1'b0;
      case (state)
        ST_IDLE: if (bus.partida) begin
          ang_q  <= bus.angulo;
          dist_q <= bus.distancia;
          idx    <= '0;
          state  <= ST_LOAD;
        end
        ST_LOAD: state <= ST_SEND;
        ST_SEND: if (fim) state <= ST_NEXT;
        ST_NEXT: if (idx == LAST_IDX) begin
          state    <= ST_DONE;
          pronto_q <= 1'b1;
        end else begin
          idx   <= idx + 4'd1;
          state <= ST_LOAD;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // The engine is idle during LOAD, so the start strobe can come straight from the state.
  uart_tx_7o2 #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart (
    .clock        (clock),
    .reset        (reset),
    .start        (state == ST_LOAD),
    .data         (char_sel),
    .saida_serial (bus.saida_serial),
    .fim          (fim)
  );

  assign bus.ocupado   = (state != ST_IDLE);
  assign bus.pronto    = pronto_q;
  assign bus.db_estado = state;

endmodule

// File: tb/tb_sonar_tx_frame.sv
// Directed bench for sonar_tx_frame: serial receiver model, frame scoreboard and timing checks.
module tb_sonar_tx_frame;
  import sonar_pkg::*;

  localparam int C   = 4;
  localparam int P   = 11 * C + 2;
  localparam int LAT = 2 + N_FRAME * P - 1;

  typedef struct {
    logic [11:0] a;
    logic [11:0] d;
    logic [63:0] chars;
  } vec_t;

  typedef struct packed {
    logic [6:0]  data;
    logic        par_ok;
    logic        frame_ok;
    logic [31:0] start;
  } rx_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  logic [6:0]  exp_q[$];
  rx_t         rx_q[$];
  logic [31:0] pronto_q[$];
  vec_t        vecs[4];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sonar_tx_frame_if bus();

  sonar_tx_frame #(.CLKS_PER_BIT(C)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  always @(negedge clk) if (bus.pronto === 1'b1) pronto_q.push_back(cyc);

  // Serial receiver: samples each bit in the middle of its period.
  initial begin
    logic [9:0] bits;
    logic       sb;
    int         s;
    forever begin
      @(negedge clk);
      if (bus.saida_serial === 1'b0) begin
        s = cyc;
        repeat (C / 2) @(negedge clk);
        sb = bus.saida_serial;
        for (int i = 0; i < 10; i++) begin
          repeat (C) @(negedge clk);
          bits[i] = bus.saida_serial;
        end
        rx_q.push_back('{data: bits[6:0], par_ok: (^bits[7:0]) == 1'b1,
                         frame_ok: (sb == 1'b0) && (bits[9:8] == 2'b11), start: s});
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load_exp(input logic [63:0] chars);
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(chars[62-8*i -: 7]);
`ifdef SONAR_TX_CRLF_EN
    exp_q.push_back(7'h0D);
    exp_q.push_back(7'h0A);
`endif
  endtask

  task automatic start_frame(input logic [11:0] a, input logic [11:0] d, output int t0);
    @(negedge clk);
    rx_q.delete();
    pronto_q.delete();
    bus.angulo    = a;
    bus.distancia = d;
    bus.partida   = 1'b1;
    t0 = cyc;
    @(negedge clk);
    #1;
    bus.partida = 1'b0;
  endtask

  task automatic finish_frame(input int t0, input int linger, input string tag);
    int waited = 0;
    while (pronto_q.size() == 0 && waited < LAT + 20) begin
      tick();
      waited++;
    end
    check({tag, " pronto_seen"}, pronto_q.size() != 0, 1);
    check({tag, " pronto_level"}, bus.pronto, 1);
    check({tag, " done_state"}, bus.db_estado, 4);
    repeat (linger) tick();
    check({tag, " pronto_count"}, pronto_q.size(), 1);
    if (pronto_q.size() > 0) check({tag, " pronto_cycle"}, pronto_q[0], t0 + LAT);
    check({tag, " char_count"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < rx_q.size()) begin
        check($sformatf("%s char%0d", tag, i), rx_q[i].data, exp_q[i]);
        check($sformatf("%s parity%0d", tag, i), rx_q[i].par_ok, 1);
        check($sformatf("%s framing%0d", tag, i), rx_q[i].frame_ok, 1);
      end
    end
    if (rx_q.size() > 1) begin
      check({tag, " first_start"}, rx_q[0].start, t0 + 2);
      check({tag, " char_spacing"}, rx_q[1].start, t0 + 2 + P);
    end
  endtask

  initial begin
    int t0;
    vecs[0] = '{a: 12'h090, d: 12'h123, chars: 64'h30_39_30_2C_31_32_33_23};
    vecs[1] = '{a: 12'h0A5, d: 12'h999, chars: 64'h30_3F_35_2C_39_39_39_23};
    vecs[2] = '{a: 12'hF07, d: 12'h4B0, chars: 64'h3F_30_37_2C_34_3F_30_23};
    vecs[3] = '{a: 12'h180, d: 12'h000, chars: 64'h31_38_30_2C_30_30_30_23};

    bus.partida   = 1'b0;
    bus.angulo    = '0;
    bus.distancia = '0;
    rst = 1'b1;
    repeat (3) tick();
    check("reset saida_serial", bus.saida_serial, 1);
    check("reset ocupado", bus.ocupado, 0);
    check("reset pronto", bus.pronto, 0);
    check("reset db_estado", bus.db_estado, 0);
    rst = 1'b0;
    repeat (3) tick();

    for (int v = 0; v < 4; v++) begin
      load_exp(vecs[v].chars);
      start_frame(vecs[v].a, vecs[v].d, t0);
      if (v == 0) begin
        check("load db_estado", bus.db_estado, 1);
        check("load ocupado", bus.ocupado, 1);
        check("load line_high", bus.saida_serial, 1);
        tick();
        check("send db_estado", bus.db_estado, 2);
        check("send start_bit", bus.saida_serial, 0);
      end
      finish_frame(t0, 5, $sformatf("vec%0d", v));
    end

    // Busy: extra partida and changed inputs mid-frame must not disturb the frame.
    load_exp(vecs[0].chars);
    start_frame(vecs[0].a, vecs[0].d, t0);
    repeat (100) tick();
    bus.partida   = 1'b1;
    bus.angulo    = 12'h555;
    bus.distancia = 12'h777;
    tick();
    bus.partida = 1'b0;
    check("busy ocupado", bus.ocupado, 1);
    finish_frame(t0, 5, "busy");

    // Back-to-back: partida in the cycle right after pronto.
    load_exp(vecs[1].chars);
    start_frame(vecs[1].a, vecs[1].d, t0);
    finish_frame(t0, 0, "b2b_first");
    load_exp(vecs[2].chars);
    start_frame(vecs[2].a, vecs[2].d, t0);
    finish_frame(t0, 5, "b2b_second");

    // Reset during character 3 abandons the frame.
    load_exp(vecs[3].chars);
    start_frame(vecs[3].a, vecs[3].d, t0);
    repeat (2 + 3 * P + 10) tick();
    check("pre_reset ocupado", bus.ocupado, 1);
    rst = 1'b1;
    tick();
    check("midreset saida_serial", bus.saida_serial, 1);
    check("midreset ocupado", bus.ocupado, 0);
    check("midreset db_estado", bus.db_estado, 0);
    check("midreset pronto", bus.pronto, 0);
    rst = 1'b0;
    repeat (60) tick();
    check("midreset no_pronto", pronto_q.size(), 0);
    start_frame(vecs[3].a, vecs[3].d, t0);
    finish_frame(t0, 5, "after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
